alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
- Front-end controller for the register-mapped ALU slave on the shared alu bus: addr, wr_data, rd_wr, enable, rd_data, res_out.
- Arbitrates round-robin between NUM_REQ command requesters.
- For each accepted command: writes operand A, operand B, then opcode into the ALU, waits a fixed result latency, samples res_out, and returns a tagged 16-bit result through a valid/ready response channel.

Parameters:
- NUM_REQ, 2: number of requesters (2..4).
- DATA_WIDTH, 8: operand / wr_data width.
- RES_WIDTH, 16: res_out width.
- RES_LATENCY, 2: cycles from the opcode-write cycle to the res_out sample cycle (1..15).

Ports:
- clk  in  1  clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*DATA_WIDTH  operand A; slice i belongs to requester i.
- req_b  in  NUM_REQ*DATA_WIDTH  operand B, same slicing.
- req_op  in  NUM_REQ*DATA_WIDTH  opcode byte, same slicing.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumer ready.
- rsp_id  out  $clog2(NUM_REQ)  index of the requester that owns the result.
- rsp_data  out  RES_WIDTH  sampled res_out.
- addr  out  2  ALU register address: 0=A, 1=B, 2=OP, 3=unused.
- wr_data  out  DATA_WIDTH  ALU write data.
- rd_wr  out  1  0=write, 1=read; this block issues writes only.
- enable  out  1  ALU access strobe.
- rd_data  in  8  ALU read data; unused, reserved.
- res_out  in  RES_WIDTH  ALU result.

Behaviour:
- Reset (reset=0, async): state=IDLE, rr_ptr=0. Outputs: req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, addr=0, wr_data=0, rd_wr=1, enable=0.
- States: IDLE, WR_A, WR_B, WR_OP, WAIT, RESP.
- IDLE:
  - Grant = first i with req_valid[i]=1, scanning from rr_ptr upward modulo NUM_REQ.
  - req_ready[grant]=1 combinationally, only in IDLE.
  - On handshake, capture a, b, op and id into holding registers, then go to WR_A.
  - rr_ptr <= grant+1, wrapping NUM_REQ-1 -> 0.
- Bus outputs are registered. Each write state drives, for exactly one cycle: enable=1, rd_wr=0, plus the addr and wr_data below.
  - WR_A: addr=0, wr_data=a.
  - WR_B: addr=1, wr_data=b.
  - WR_OP: addr=2, wr_data=op.
  - All other states: enable=0, rd_wr=1.
- WAIT: counter loads RES_LATENCY-1 on entry. On the cycle the counter reaches 0, capture rsp_data<=res_out, go to RESP, and set rsp_valid=1 at the next edge.
- RESP:
  - Hold rsp_valid, rsp_id and rsp_data stable until rsp_ready=1.
  - On handshake, clear rsp_valid and return to IDLE.
- Latency:
  - Handshake at cycle T, so ALU writes occur at T+1, T+2, T+3.
  - res_out is sampled at T+3+RES_LATENCY; rsp_valid rises at T+4+RES_LATENCY.
  - Minimum issue interval is RES_LATENCY+5 cycles when rsp_ready is held at 1.
- Single outstanding command; no command is accepted while not in IDLE.
- req_valid dropped before its handshake: no command is taken and no state changes.
- Operands are captured at the handshake; later changes on req_* have no effect.
- rsp_ready=1 while rsp_valid=0 has no effect.
- Reset asserted mid-sequence aborts immediately and returns all outputs to their reset values. The ALU may hold partial operands; the next command rewrites all three registers.
- rd_data is ignored; a readback path is reserved for a later revision.

Decomposition:
- Shared package alu_pkg:
  - Constants ALU_ADDR_A=2'd0, ALU_ADDR_B=2'd1, ALU_ADDR_OP=2'd2.
  - RD=1'b1, WR=1'b0.
  - Typedef seq_state_e for the state enum.
  - Typedef alu_cmd_t struct {a, b, op, id}.
- One sub-module, rr_arbiter: NUM_REQ-wide round-robin grant with an rr_ptr input and a one-hot grant output.

Test Plan:
1. Reset, then req_valid=01, a=0x12, b=0x34, op=0x01; ALU model gives res_out=0x0046 → bus writes (0,0x12), (1,0x34), (2,0x01) on consecutive cycles; rsp_valid at handshake+6 with id=0, data=0x0046.
2. req_valid=11 held continuously, rsp_ready=1 → grants alternate 0,1,0,1; each issue is 7 cycles apart; rsp_id sequence is 0,1,0,1.
3. rsp_ready=0 for 5 cycles after rsp_valid rises → rsp_data/rsp_id stable; req_ready stays 0; no bus enable is issued.
4. Change req_a[0] to 0xFF on the cycle after the handshake → ALU still receives 0x12.
5. Assert reset during WR_B → enable=0, rsp_valid=0 immediately. Reissuing a=0x05, b=0x07, op=0x02 gives three fresh writes and a correct result.
6. res_out=0xFFFF (full width) → rsp_data=0xFFFF with no truncation; rr_ptr wraps from 1 to 0 correctly with NUM_REQ=2.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the register-mapped ALU bus and its command sequencer.
// The ALU registers are byte-wide, so command fields are fixed at 8 bits.
package alu_pkg;

    localparam logic [1:0] ALU_ADDR_A  = 2'd0;
    localparam logic [1:0] ALU_ADDR_B  = 2'd1;
    localparam logic [1:0] ALU_ADDR_OP = 2'd2;

    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;

    localparam int CMD_DW  = 8;
    localparam int CMD_IDW = 2;

    typedef enum logic [2:0] {
        IDLE,
        WR_A,
        WR_B,
        WR_OP,
        WAIT,
        RESP
    } seq_state_e;

    typedef struct packed {
        logic [CMD_DW-1:0]  a;
        logic [CMD_DW-1:0]  b;
        logic [CMD_DW-1:0]  op;
        logic [CMD_IDW-1:0] id;
    } alu_cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: the first requester at or above rr_ptr wins, else the lowest requester overall.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic [NUM_REQ-1:0] hi;
    logic               found;

    always_comb begin
        hi    = '0;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hi[i] = req[i] && (i >= int'(rr_ptr));
        end
        // Upper half first, then wrap to the bottom of the ring.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && hi[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Front-end for the ALU slave: arbitrates requesters, writes A/B/OP, waits the result
// latency, then returns the sampled res_out on a valid/ready response channel.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int DATA_WIDTH  = 8,
    parameter int RES_WIDTH   = 16,
    parameter int RES_LATENCY = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_op,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]      rsp_id,
    output logic [RES_WIDTH-1:0]            rsp_data,
    output logic [1:0]                      addr,
    output logic [DATA_WIDTH-1:0]           wr_data,
    output logic                            rd_wr,
    output logic                            enable,
    input  logic [7:0]                      rd_data,
    input  logic [RES_WIDTH-1:0]            res_out
);

    localparam int IW    = $clog2(NUM_REQ);
    localparam int CNT_W = 4;

    seq_state_e         state, state_n;
    logic [IW-1:0]      rr_ptr, ptr_next, grant_idx;
    logic [NUM_REQ-1:0] grant;
    logic               hs;
    alu_cmd_t           cmd_q, cmd_d;
    logic [CNT_W-1:0]   cnt;
    logic               bus_en_d;
    logic [1:0]         bus_addr_d;
    logic [DATA_WIDTH-1:0] bus_data_d;
    logic               rd_data_unused;

    assign rd_data_unused = ^rd_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (IW)
    ) u_arb (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .grant  (grant)
    );

    assign req_ready = (state == IDLE) ? grant : '0;
    assign hs        = |req_ready;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) grant_idx = IW'(i);
        end
    end

    assign ptr_next = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        cmd_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                cmd_d.a  = req_a[i*DATA_WIDTH +: DATA_WIDTH];
                cmd_d.b  = req_b[i*DATA_WIDTH +: DATA_WIDTH];
                cmd_d.op = req_op[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        cmd_d.id = CMD_IDW'(grant_idx);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (hs) state_n = WR_A;
            WR_A:    state_n = WR_B;
            WR_B:    state_n = WR_OP;
            WR_OP:   state_n = WAIT;
            WAIT:    if (cnt == '0) state_n = RESP;
            RESP:    if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Bus outputs are registered off state_n so each write lands in its own state's cycle.
    // WR_A data comes straight from the granted requester since cmd_q loads on the same edge.
    always_comb begin
        bus_en_d   = 1'b0;
        bus_addr_d = addr;
        bus_data_d = wr_data;
        case (state_n)
            WR_A:  begin bus_en_d = 1'b1; bus_addr_d = ALU_ADDR_A;  bus_data_d = cmd_d.a;  end
            WR_B:  begin bus_en_d = 1'b1; bus_addr_d = ALU_ADDR_B;  bus_data_d = cmd_q.b;  end
            WR_OP: begin bus_en_d = 1'b1; bus_addr_d = ALU_ADDR_OP; bus_data_d = cmd_q.op; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr    <= '0;
            cmd_q     <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            enable    <= 1'b0;
            rd_wr     <= RD;
            addr      <= ALU_ADDR_A;
            wr_data   <= '0;
        end else begin
            if (hs) begin
                cmd_q  <= cmd_d;
                rr_ptr <= ptr_next;
            end
            if (state == WR_OP)
                cnt <= CNT_W'(RES_LATENCY - 1);
            else if (state == WAIT && cnt != '0)
                cnt <= cnt - 1'b1;
            if (state == WAIT && cnt == '0) begin
                rsp_data <= res_out;
                rsp_id   <= IW'(cmd_q.id);
            end
            rsp_valid <= (state_n == RESP);
            enable    <= bus_en_d;
            rd_wr     <= bus_en_d ? WR : RD;
            addr      <= bus_addr_d;
            wr_data   <= bus_data_d;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomized bench for alu_cmd_sequencer against a cycle-timeline transaction model
// and a behavioural ALU slave that only presents a valid result at the stated latency.
module tb_alu_cmd_sequencer;

    localparam int N  = 2;
    localparam int DW = 8;
    localparam int RW = 16;
    localparam int L  = 2;
    localparam int IW = 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [N-1:0]      req_valid = '0, req_ready;
    logic [N*DW-1:0]   req_a = '0, req_b = '0, req_op = '0;
    logic              rsp_valid, rsp_ready = 1'b0;
    logic [IW-1:0]     rsp_id;
    logic [RW-1:0]     rsp_data;
    logic [1:0]        addr;
    logic [DW-1:0]     wr_data;
    logic              rd_wr, enable;
    logic [7:0]        rd_data;
    logic [RW-1:0]     res_out;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .RES_WIDTH(RW), .RES_LATENCY(L)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data),
        .addr(addr), .wr_data(wr_data), .rd_wr(rd_wr), .enable(enable),
        .rd_data(rd_data), .res_out(res_out)
    );

    // ALU slave: result is meaningful only L cycles after the opcode write, junk otherwise.
    logic [7:0]  alu_reg [4];
    int          op_age = 1000;
    logic [RW-1:0] junk = '0;

    function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        case (op[1:0])
            2'd0:    return {a, b};
            2'd1:    return 16'(a) + 16'(b);
            2'd2:    return 16'(a) * 16'(b);
            default: return 16'(a) - 16'(b);
        endcase
    endfunction

    always @(posedge clk) begin
        junk <= RW'($urandom);
        if (enable && !rd_wr) alu_reg[addr] <= wr_data;
        if (enable && !rd_wr && addr == 2'd2) op_age <= 1;
        else if (op_age < 1000)               op_age <= op_age + 1;
    end

    assign res_out = (op_age == L) ? alu_f(alu_reg[0], alu_reg[1], alu_reg[2]) : junk;
    assign rd_data = 8'h5A;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Transaction model
    bit         busy = 1'b0;
    int         t_hs = 0, mrr = 0, mid = 0, prev_hs = -1;
    bit         gap_chk = 1'b0;
    logic [7:0] ma, mb, mop;

    logic [N-1:0]    nv = '0;
    logic [N*DW-1:0] na = '0, nb = '0, nop = '0;
    logic            nrdy = 1'b0;

    task automatic check_cycle();
        logic [N-1:0] exp_rdy;
        int k;
        exp_rdy = '0;
        if (!busy) begin
            for (int j = 0; j < N; j++) begin
                int idx;
                idx = (mrr + j) % N;
                if (exp_rdy == '0 && req_valid[idx]) exp_rdy[idx] = 1'b1;
            end
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("idle_enable", 32'(enable), 32'd0);
            chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
            for (int i = 0; i < N; i++) begin
                if (exp_rdy[i]) begin
                    ma  = req_a[i*DW +: DW];
                    mb  = req_b[i*DW +: DW];
                    mop = req_op[i*DW +: DW];
                    mid = i;
                    mrr = (i + 1) % N;
                    busy = 1'b1;
                    t_hs = cyc;
                    if (gap_chk && prev_hs >= 0) chk("issue_gap", 32'(cyc - prev_hs), 32'(L + 5));
                    prev_hs = cyc;
                end
            end
        end else begin
            k = cyc - t_hs;
            chk("busy_req_ready", 32'(req_ready), 32'd0);
            if (k >= 1 && k <= 3) begin
                chk("wr_enable", 32'(enable), 32'd1);
                chk("wr_rd_wr", 32'(rd_wr), 32'd0);
                chk("wr_addr", 32'(addr), 32'(k - 1));
                chk("wr_data", 32'(wr_data), 32'((k == 1) ? ma : (k == 2) ? mb : mop));
            end else begin
                chk("nowr_enable", 32'(enable), 32'd0);
                chk("nowr_rd_wr", 32'(rd_wr), 32'd1);
            end
            if (k >= 4 + L) begin
                chk("rsp_valid", 32'(rsp_valid), 32'd1);
                chk("rsp_id", 32'(rsp_id), 32'(mid));
                chk("rsp_data", 32'(rsp_data), 32'(alu_f(ma, mb, mop)));
                if (rsp_ready) busy = 1'b0;
            end else begin
                chk("early_rsp_valid", 32'(rsp_valid), 32'd0);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        req_valid = nv; req_a = na; req_b = nb; req_op = nop; rsp_ready = nrdy;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic drain();
        nv = '0; nrdy = 1'b1;
        for (int i = 0; i < 40 && busy; i++) step();
        chk("drain_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #22;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_rd_wr", 32'(rd_wr), 32'd1);
        chk("rst_enable", 32'(enable), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Single command from requester 0, operand changed right after handshake.
        nv = 2'b01; na = {8'h00, 8'h12}; nb = {8'h00, 8'h34}; nop = {8'h00, 8'h01}; nrdy = 1'b1;
        step();
        nv = '0; na = {8'h00, 8'hFF};
        for (int i = 0; i < 10; i++) step();
        drain();

        // Both requesters held valid, consumer always ready: alternate grants, fixed gap.
        gap_chk = 1'b1; prev_hs = -1;
        nv = 2'b11; na = {8'h21, 8'h43}; nb = {8'h05, 8'h09}; nop = {8'h02, 8'h00}; nrdy = 1'b1;
        for (int i = 0; i < 30; i++) step();
        gap_chk = 1'b0;
        drain();

        // Consumer stalls five cycles after rsp_valid rises.
        nv = 2'b11; na = {8'h77, 8'h31}; nb = {8'h11, 8'h0F}; nop = {8'h03, 8'h01};
        for (int i = 0; i < 30; i++) begin
            nrdy = busy && ((cyc + 1 - t_hs) >= 4 + L + 5);
            step();
        end
        drain();

        // Reset during WR_B, then a fresh command must rewrite all three registers.
        nv = 2'b01; na = {8'h00, 8'h77}; nb = {8'h00, 8'h66}; nop = {8'h00, 8'h03}; nrdy = 1'b1;
        step();
        nv = '0;
        step();
        @(posedge clk);
        #1;
        cyc++;
        req_valid = '0;
        reset = 1'b0;
        #1;
        chk("abort_enable", 32'(enable), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_rd_wr", 32'(rd_wr), 32'd1);
        chk("abort_addr", 32'(addr), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd0);
        busy = 1'b0; mrr = 0;
        #2 reset = 1'b1;
        @(negedge clk);
        check_cycle();
        nv = 2'b01; na = {8'h00, 8'h05}; nb = {8'h00, 8'h07}; nop = {8'h00, 8'h02};
        step();
        drain();

        // Full-width result from requester 1, then pointer wraps back to requester 0.
        nv = 2'b10; na = {8'h00, 8'h00}; nb = {8'h01, 8'h00}; nop = {8'h03, 8'h00};
        step();
        nv = '0;
        drain();
        nv = 2'b11;
        step();
        drain();

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            nv   = N'($urandom);
            na   = (N*DW)'($urandom);
            nb   = (N*DW)'($urandom);
            nop  = (N*DW)'($urandom);
            nrdy = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
